// File: rtl/req_ack_responder_if.sv
// Single-pulse req/ack handshake bundle: requester drives req, responder returns ack plus status.
// Combinational wiring only; the handshake has no backpressure beyond the responder's minimum request spacing.
interface req_ack_responder_if #(
    parameter int CNT_WIDTH = 8
);
    logic                 req;
    logic                 ack;
    logic                 busy;
    logic [CNT_WIDTH-1:0] req_count;
    logic [CNT_WIDTH-1:0] ack_count;
    logic                 err_gap;

    modport master (
        output req,
        input  ack, busy, req_count, ack_count, err_gap
    );

    modport slave (
        input  req,
        output ack, busy, req_count, ack_count, err_gap
    );
endinterface

// File: rtl/req_ack_responder.sv
// Accepts a req pulse in IDLE and returns one registered ack pulse ACK_LATENCY cycles later.
// No backpressure: a req arriving before MIN_REQ_GAP has elapsed is dropped and flags sticky err_gap.
module req_ack_responder #(
    parameter int ACK_LATENCY = 4,
    parameter int MIN_REQ_GAP = 8,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    req_ack_responder_if.slave   bus
);
    localparam int LAT_W = (ACK_LATENCY > 1) ? $clog2(ACK_LATENCY) : 1;
    localparam int GAP_W = $clog2(MIN_REQ_GAP + 1);
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(ACK_LATENCY - 1);
    localparam logic [GAP_W-1:0] GAP_MAX  = GAP_W'(MIN_REQ_GAP);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(MIN_REQ_GAP - 1);
    localparam bit USE_HOLDOFF = (MIN_REQ_GAP > ACK_LATENCY + 1);

    generate
        if (ACK_LATENCY < 1 || MIN_REQ_GAP <= ACK_LATENCY || CNT_WIDTH < 1) begin : g_bad_params
            $error("req_ack_responder: illegal ACK_LATENCY/MIN_REQ_GAP/CNT_WIDTH combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ACK     = 2'd2,
        HOLDOFF = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [LAT_W-1:0]     lat_cnt_q, lat_cnt_d;
    logic [GAP_W-1:0]     gap_cnt_q, gap_cnt_d;
    logic [CNT_WIDTH-1:0] req_cnt_q, req_cnt_d;
    logic [CNT_WIDTH-1:0] ack_cnt_q, ack_cnt_d;
    logic                 err_q, err_d;
    logic                 ack_q, ack_d;
    logic                 accept;

    always_comb begin
        state_d   = state_q;
        lat_cnt_d = lat_cnt_q;
        gap_cnt_d = gap_cnt_q;
        req_cnt_d = req_cnt_q;
        ack_cnt_d = ack_cnt_q;
        err_d     = err_q;
        accept    = 1'b0;

        // Gap counter tracks cycles since acceptance, in parallel with the latency counter
        if (state_q == IDLE) begin
            gap_cnt_d = '0;
        end else if (gap_cnt_q != GAP_MAX) begin
            gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.req) begin
                    accept    = 1'b1;
                    req_cnt_d = req_cnt_q + CNT_WIDTH'(1);
                    lat_cnt_d = LAT_LOAD;
                    gap_cnt_d = GAP_W'(1);
                    state_d   = (ACK_LATENCY == 1) ? ACK : PENDING;
                end
            end
            PENDING: begin
                lat_cnt_d = lat_cnt_q - LAT_W'(1);
                if (lat_cnt_q == LAT_W'(1)) begin
                    state_d = ACK;
                end
            end
            ACK: begin
                ack_cnt_d = ack_cnt_q + CNT_WIDTH'(1);
                state_d   = USE_HOLDOFF ? HOLDOFF : IDLE;
            end
            HOLDOFF: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A req outside IDLE, including the ack cycle itself, is dropped and flagged
        if (bus.req && state_q != IDLE) begin
            err_d = 1'b1;
        end

        ack_d = (state_d == ACK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            lat_cnt_q <= '0;
            gap_cnt_q <= '0;
            req_cnt_q <= '0;
            ack_cnt_q <= '0;
            err_q     <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            req_cnt_q <= req_cnt_d;
            ack_cnt_q <= ack_cnt_d;
            err_q     <= err_d;
            ack_q     <= ack_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.req_count = req_cnt_q;
    assign bus.ack_count = ack_cnt_q;
    assign bus.err_gap   = err_q;

`ifdef FORMAL
    // Bit i records an acceptance i+1 cycles ago
    logic [ACK_LATENCY-1:0] acc_hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_hist_q <= '0;
        end else begin
            acc_hist_q <= ACK_LATENCY'({acc_hist_q, accept});
        end
    end

    a_ack_needs_accept: assert property (@(posedge clk) disable iff (rst)
        !acc_hist_q[ACK_LATENCY-1] |-> !bus.ack);
    a_ack_single_cycle: assert property (@(posedge clk) disable iff (rst)
        bus.ack |=> !bus.ack);
    a_count_balance: assert property (@(posedge clk) disable iff (rst)
        (bus.ack_count == bus.req_count) || (bus.ack_count + CNT_WIDTH'(1) == bus.req_count));
    a_one_outstanding: assert property (@(posedge clk) disable iff (rst)
        (bus.ack_count != bus.req_count) |-> bus.busy);
`endif
endmodule

// File: tb/tb_req_ack_responder.sv
// Directed bench: default-parameter responder for latency/gap/reset cases, and a fast
// ACK_LATENCY=1/MIN_REQ_GAP=2 instance for back-to-back traffic and counter wrap.
module tb_req_ack_responder;
    logic clk = 1'b0;
    logic rst;
    int   n_chk = 0;
    int   n_bad = 0;
    int   c     = 0;

    always #5 clk = ~clk;

    req_ack_responder_if #(.CNT_WIDTH(8)) b0 ();
    req_ack_responder_if #(.CNT_WIDTH(8)) b1 ();

    req_ack_responder #(.ACK_LATENCY(4), .MIN_REQ_GAP(8), .CNT_WIDTH(8)) u_dut0 (
        .clk (clk),
        .rst (rst),
        .bus (b0.slave)
    );

    req_ack_responder #(.ACK_LATENCY(1), .MIN_REQ_GAP(2), .CNT_WIDTH(8)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: cycle %0d got %0d want %0d", tag, c, got, exp);
        end
    endtask

    task tick;
        @(posedge clk);
        #1;
        c++;
    endtask

    // Reset held through cycles 0 and 1; returns at cycle 2 with rst low
    task start_scn;
        rst    = 1'b1;
        b0.req = 1'b0;
        b1.req = 1'b0;
        c      = 0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        b0.req = 1'b0;
        b1.req = 1'b0;
        @(posedge clk);
        #1;

        // single request: reset state, ack timing, busy window, counts
        start_scn();
        chk("rst_ack", b0.ack, 0);
        chk("rst_busy", b0.busy, 0);
        chk("rst_reqcnt", b0.req_count, 0);
        chk("rst_ackcnt", b0.ack_count, 0);
        chk("rst_err", b0.err_gap, 0);
        while (c <= 24) begin
            b0.req = (c == 10);
            chk("s1_ack", b0.ack, c == 14);
            chk("s1_busy", b0.busy, c >= 11 && c <= 17);
            if (c == 15) begin
                chk("s1_reqcnt", b0.req_count, 1);
                chk("s1_ackcnt", b0.ack_count, 1);
            end
            tick();
        end

        // two requests exactly MIN_REQ_GAP apart
        start_scn();
        while (c <= 28) begin
            b0.req = (c == 10 || c == 18);
            chk("s2_ack", b0.ack, c == 14 || c == 22);
            chk("s2_busy", b0.busy, (c >= 11 && c <= 17) || (c >= 19 && c <= 25));
            chk("s2_err", b0.err_gap, 0);
            if (c == 23) begin
                chk("s2_reqcnt", b0.req_count, 2);
                chk("s2_ackcnt", b0.ack_count, 2);
            end
            tick();
        end

        // second request lands on the ack cycle: dropped, sticky error
        start_scn();
        while (c <= 26) begin
            b0.req = (c == 10 || c == 14);
            chk("s3_ack", b0.ack, c == 14);
            chk("s3_busy", b0.busy, c >= 11 && c <= 17);
            chk("s3_err", b0.err_gap, c >= 15);
            if (c == 20) begin
                chk("s3_reqcnt", b0.req_count, 1);
                chk("s3_ackcnt", b0.ack_count, 1);
            end
            tick();
        end

        // reset while an ack is pending cancels it; later request works normally
        start_scn();
        while (c <= 26) begin
            b0.req = (c == 10 || c == 16);
            rst    = (c == 12);
            chk("s4_ack", b0.ack, c == 20);
            chk("s4_busy", b0.busy, (c >= 11 && c <= 12) || (c >= 17 && c <= 23));
            chk("s4_reqcnt", b0.req_count, ((c >= 11 && c <= 12) || c >= 17) ? 1 : 0);
            chk("s4_ackcnt", b0.ack_count, (c >= 21) ? 1 : 0);
            chk("s4_err", b0.err_gap, 0);
            tick();
        end

        // long idle period after reset
        start_scn();
        while (c < 102) begin
            chk("s6_ack", b0.ack, 0);
            chk("s6_busy", b0.busy, 0);
            tick();
        end
        chk("s6_reqcnt", b0.req_count, 0);
        chk("s6_ackcnt", b0.ack_count, 0);
        chk("s6_err", b0.err_gap, 0);

        // fast instance: 300 back-to-back requests, counters wrap to 300 mod 256
        start_scn();
        while (c <= 612) begin
            b1.req = (c >= 10 && c <= 608 && (c % 2) == 0);
            chk("s5_ack", b1.ack, c >= 11 && c <= 609 && (c % 2) == 1);
            chk("s5_busy", b1.busy, c >= 11 && c <= 609 && (c % 2) == 1);
            chk("s5_err", b1.err_gap, 0);
            tick();
        end
        chk("s5_reqcnt", b1.req_count, 44);
        chk("s5_ackcnt", b1.ack_count, 44);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule

// File: doc/req_ack_responder.md
Name: req_ack_responder

Overview:
- Downstream responder for the single-pulse req/ack handshake: consumes `req` pulses and returns exactly one `ack` pulse a fixed latency later.
- Enforces the minimum request spacing and flags violations.
- Provides accepted-request and ack counts so staged sim/formal flows can check bounded progress.
- Replaces the free-running environment `ack` with a real driver, so the handshake can be verified end to end.

Parameters:
- ACK_LATENCY, 4: cycles from accepted req to ack; legal range >= 1.
- MIN_REQ_GAP, 8: minimum cycles between consecutive accepted reqs; must be > ACK_LATENCY.
- CNT_WIDTH, 8: width of the req/ack counters.

Ports:
- clk  input  1  single clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- req  input  1  request pulse, sampled each posedge.
- ack  output  1  acknowledge pulse, registered, one cycle wide.
- busy  output  1  high while any state other than IDLE.
- req_count  output  CNT_WIDTH  number of accepted reqs, wraps modulo 2^CNT_WIDTH.
- ack_count  output  CNT_WIDTH  number of acks issued, wraps modulo 2^CNT_WIDTH.
- err_gap  output  1  sticky: a req arrived while not in IDLE.

Behaviour:
- Interface is fixed: one clock (`clk`); reset `rst` is synchronous and active-high.
- Reset, sampled at posedge: state=IDLE, ack=0, busy=0, req_count=0, ack_count=0, err_gap=0, internal counters=0.
  - Any pending ack is cancelled.
  - req is ignored in any cycle where rst is high.
- Timing reference: req high in cycle t is accepted in IDLE. ack is high in cycle t+ACK_LATENCY only; the next req is accepted from cycle t+MIN_REQ_GAP.
- FSM states: IDLE, PENDING, ACK, HOLDOFF.
  - IDLE, req=1: accept; req_count+1; load lat_cnt; go to PENDING. If ACK_LATENCY==1, go directly to ACK.
  - PENDING: decrement lat_cnt; go to ACK so that ack is registered high in cycle t+ACK_LATENCY.
  - ACK: ack=1 for this cycle only; ack_count+1. Go to HOLDOFF if MIN_REQ_GAP > ACK_LATENCY+1, else IDLE.
  - HOLDOFF: gap_cnt counts cycles since t; return to IDLE so that IDLE holds in cycle t+MIN_REQ_GAP.
- Gap counter: starts at acceptance and runs in parallel with the latency counter. Sized ceil(log2(MIN_REQ_GAP+1)); saturates, never wraps.
- Request outside IDLE (PENDING/ACK/HOLDOFF):
  - err_gap set (sticky until rst).
  - The req is dropped: no ack, no req_count increment, timers not restarted.
  - The in-flight ack still fires on schedule.
- req in the same cycle ack is high counts as a violation, because MIN_REQ_GAP > ACK_LATENCY.
- Counter wrap: all-ones + 1 = 0; no flag.
- Invariants:
  - At most one request is outstanding.
  - ack_count == req_count or req_count-1, modulo 2^CNT_WIDTH.
  - ack is never high two consecutive cycles.
  - ack is high only if req was accepted exactly ACK_LATENCY cycles earlier.
- Formal: under the FORMAL define, the block asserts the invariants above, and asserts `!ack` when there was no accepted req ACK_LATENCY cycles ago.
- Parameter check: illegal parameter combinations must fail elaboration.

Test Plan:
- rst 2 cycles, then req pulse at cycle 10 → ack high only at cycle 14; busy high cycles 11–17; req_count=1, ack_count=1 at cycle 15.
- reqs at cycles 10 and 18 → acks at 14 and 22; err_gap=0; counts both reach 2.
- reqs at cycles 10 and 14 → ack only at 14; err_gap=1 from cycle 15 and held; req_count=1, ack_count=1.
- req at 10, rst high at 12 → no ack at 14; all outputs 0 from cycle 13; req at 16 → ack at 20.
- ACK_LATENCY=1, MIN_REQ_GAP=2, reqs every 2 cycles ×300 with CNT_WIDTH=8 → an ack follows each req by one cycle; counters wrap to 44 (300 mod 256); err_gap=0.
- No req for 100 cycles after reset → ack never high; busy=0; counters 0.
